// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   owner_e    - which core port issued an in-flight read
//   inflight_t - one owner-pipeline stage {valid, owner}
//   sat_inc32  - saturating 32-bit increment used by the optional statistics
//                counters (MEM_ARB_STATS_EN)
package mem_arb_pkg;

   localparam int unsigned MEM_LAT_MAX = 4;
   localparam int unsigned DSTREAK_W   = 4;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } inflight_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
      if (en && (val != 32'hFFFF_FFFF)) begin
         return val + 32'd1;
      end
      return val;
   endfunction

endpackage

// File: rtl/arb_inflight_pipe.sv
// arb_inflight_pipe: DEPTH-stage shift register of {valid, owner} tags that
// follows each read through the fixed-latency memory so its data can be
// steered back to the port that issued it.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, invalidates every stage
//   push  - tag entering stage 0 this cycle (valid = 0 when no read issued)
//   head  - tag leaving the last stage, aligned with memory read data
module arb_inflight_pipe
   import mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  inflight_t push,
   output inflight_t head
);

   inflight_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= push;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign head = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency, pipelined memory
// between the instruction-fetch port (i_*) and the data port (d_*).
// At most one access per cycle; data side has priority, but after
// MAX_DSTREAK consecutive data grants with fetch waiting, fetch is forced.
// Read data is routed back by an owner pipeline MEM_LAT stages deep.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   i_req/i_addr               - fetch read request
//   i_gnt/i_rvalid/i_rdata     - fetch accept, read-data valid, read data
//   d_req/d_addr/d_we/d_wdata  - data request (d_we = 0 means read)
//   d_gnt/d_rvalid/d_rdata     - data accept, read-data valid, read data
//   m_en/m_addr/m_we/m_wdata   - memory strobe and command
//   m_rdata                    - memory read data, MEM_LAT cycles after strobe
// Optional: define MEM_ARB_STATS_EN to add saturating 32-bit counters
//   stat_conflict, stat_i_wait, stat_d_wait.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned MEM_LAT     = 1,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic [3:0]    d_we,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic [AW-1:0] m_addr,
   output logic [3:0]    m_we,
   output logic [DW-1:0] m_wdata,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0]   stat_conflict,
   output logic [31:0]   stat_i_wait,
   output logic [31:0]   stat_d_wait,
`endif
   input  logic [DW-1:0] m_rdata
);

   // Clamp to the legal latency range so the owner pipe is never zero-deep.
   localparam int unsigned PIPE_DEPTH = (MEM_LAT < 1) ? 1 :
                                        ((MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT);
   localparam logic [DSTREAK_W-1:0] DSTREAK_LIMIT = DSTREAK_W'(MAX_DSTREAK);

   logic [DSTREAK_W-1:0] dstreak_q, dstreak_d;
   logic [AW-1:0]        addr_q;
   logic [DW-1:0]        wdata_q;
   logic                 fetch_forced;
   inflight_t            push;
   inflight_t            head;

   // Grant and memory command
   always_comb begin
      fetch_forced = i_req && (dstreak_q == DSTREAK_LIMIT);
      // Grants are held low for the whole time reset is asserted.
      d_gnt   = rst_n && d_req && !fetch_forced;
      i_gnt   = rst_n && i_req && !d_gnt;
      m_en    = i_gnt || d_gnt;
      m_we    = d_gnt ? d_we : 4'b0000;
      m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : addr_q);
      m_wdata = d_gnt ? d_wdata : wdata_q;

      push       = '0;
      push.valid = i_gnt || (d_gnt && (d_we == 4'b0000));
      push.owner = d_gnt ? OWN_D : OWN_I;
   end

   // Data-streak counter: only runs while fetch is actually waiting.
   always_comb begin
      dstreak_d = dstreak_q;
      if (!i_req || i_gnt) begin
         dstreak_d = '0;
      end else if (d_gnt && (dstreak_q < DSTREAK_LIMIT)) begin
         dstreak_d = dstreak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dstreak_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         dstreak_q <= dstreak_d;
         if (m_en) begin
            addr_q <= m_addr;
         end
         if (d_gnt) begin
            wdata_q <= d_wdata;
         end
      end
   end

   arb_inflight_pipe #(
      .DEPTH (PIPE_DEPTH)
   ) u_inflight (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .head  (head)
   );

   // Read-data return: the tag at the pipe head is aligned with m_rdata.
   always_comb begin
      i_rvalid = head.valid && (head.owner == OWN_I);
      d_rvalid = head.valid && (head.owner == OWN_D);
      i_rdata  = i_rvalid ? m_rdata : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] conflict_q, i_wait_q, d_wait_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= '0;
         i_wait_q   <= '0;
         d_wait_q   <= '0;
      end else begin
         conflict_q <= sat_inc32(conflict_q, i_req && d_req);
         i_wait_q   <= sat_inc32(i_wait_q, i_req && !i_gnt);
         d_wait_q   <= sat_inc32(d_wait_q, d_req && !d_gnt);
      end
   end

   assign stat_conflict = conflict_q;
   assign stat_i_wait   = i_wait_q;
   assign stat_d_wait   = d_wait_q;
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT = 1 and 3) share one
// directed stimulus stream. Each has its own behavioural memory; a reference
// model checks every output on every falling edge, and directed literal
// expectations pin the model at the key points.
module tb_mem_port_arbiter;

   localparam int unsigned MAXD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_req;
   logic [31:0] d_addr;
   logic [3:0]  d_we;
   logic [31:0] d_wdata;

   logic [1:0]  i_gnt_w, i_rvalid_w, d_gnt_w, d_rvalid_w, m_en_w;
   logic [31:0] i_rdata_w [2];
   logic [31:0] d_rdata_w [2];
   logic [31:0] m_addr_w  [2];
   logic [31:0] m_wdata_w [2];
   logic [31:0] m_rdata_w [2];
   logic [3:0]  m_we_w    [2];
`ifdef MEM_ARB_STATS_EN
   logic [31:0] sc_w [2];
   logic [31:0] si_w [2];
   logic [31:0] sd_w [2];
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input logic [7:0] idx);
      return {8'hA5, 16'h0000, idx};
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   function automatic string gtag(input int k);
      if (d_gnt_w[k]) return "D";
      if (i_gnt_w[k]) return "I";
      return "-";
   endfunction

   function automatic string rtag(input int k);
      if (i_rvalid_w[k]) return "I";
      if (d_rvalid_w[k]) return "D";
      return "-";
   endfunction

   // DUT instances with behavioural pipelined memories
   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int unsigned L = (k == 0) ? 1 : 3;
      logic [31:0] mem [256];
      logic [31:0] dl  [L];

      mem_port_arbiter #(
         .AW          (32),
         .DW          (32),
         .MEM_LAT     (L),
         .MAX_DSTREAK (MAXD)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_req    (i_req),
         .i_addr   (i_addr),
         .i_gnt    (i_gnt_w[k]),
         .i_rvalid (i_rvalid_w[k]),
         .i_rdata  (i_rdata_w[k]),
         .d_req    (d_req),
         .d_addr   (d_addr),
         .d_we     (d_we),
         .d_wdata  (d_wdata),
         .d_gnt    (d_gnt_w[k]),
         .d_rvalid (d_rvalid_w[k]),
         .d_rdata  (d_rdata_w[k]),
         .m_en     (m_en_w[k]),
         .m_addr   (m_addr_w[k]),
         .m_we     (m_we_w[k]),
         .m_wdata  (m_wdata_w[k]),
`ifdef MEM_ARB_STATS_EN
         .stat_conflict (sc_w[k]),
         .stat_i_wait   (si_w[k]),
         .stat_d_wait   (sd_w[k]),
`endif
         .m_rdata  (m_rdata_w[k])
      );

      always @(posedge clk) begin
         if (!rst_n) begin
            for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
         end else if (m_en_w[k] && (m_we_w[k] != 4'b0000)) begin
            for (int b = 0; b < 4; b++) begin
               if (m_we_w[k][b]) mem[m_addr_w[k][9:2]][8*b +: 8] <= m_wdata_w[k][8*b +: 8];
            end
         end
         // Junk on the bus when nothing was read, so unrouted data shows up.
         dl[0] <= (m_en_w[k] && (m_we_w[k] == 4'b0000)) ? mem[m_addr_w[k][9:2]] : $urandom();
         for (int s = 1; s < L; s++) dl[s] <= dl[s-1];
      end

      assign m_rdata_w[k] = dl[L-1];
   end

   // Reference model: expected returns are scheduled in a time-slot ring.
   int unsigned streak     [2];
   logic        slot_v     [2][8];
   logic        slot_d     [2][8];
   logic [31:0] slot_data  [2][8];
   logic [31:0] ref_mem    [2][256];
   logic [31:0] last_addr  [2];
   logic [31:0] last_wdata [2];
   logic        have_addr  [2];
   logic        have_wdata [2];

   task automatic model_check(input int k);
      logic  ei, ed, iv, dv;
      logic [31:0] rdat;
      int    s, s2;
      string p;
      p = $sformatf("inst%0d cyc%0d", k, cyc);
      if (!rst_n) begin
         chk({p, " rst i_gnt"}, 32'(i_gnt_w[k]), 32'd0);
         chk({p, " rst d_gnt"}, 32'(d_gnt_w[k]), 32'd0);
         chk({p, " rst m_en"}, 32'(m_en_w[k]), 32'd0);
         chk({p, " rst m_we"}, 32'(m_we_w[k]), 32'd0);
         chk({p, " rst i_rvalid"}, 32'(i_rvalid_w[k]), 32'd0);
         chk({p, " rst d_rvalid"}, 32'(d_rvalid_w[k]), 32'd0);
         chk({p, " rst i_rdata"}, i_rdata_w[k], 32'd0);
         chk({p, " rst d_rdata"}, d_rdata_w[k], 32'd0);
         streak[k]     = 0;
         have_addr[k]  = 1'b0;
         have_wdata[k] = 1'b0;
         for (int j = 0; j < 8; j++) slot_v[k][j] = 1'b0;
         for (int a = 0; a < 256; a++) ref_mem[k][a] = pat(8'(a));
         return;
      end

      ed = d_req && !(i_req && (streak[k] == MAXD));
      ei = i_req && !ed;
      chk({p, " i_gnt"}, 32'(i_gnt_w[k]), 32'(ei));
      chk({p, " d_gnt"}, 32'(d_gnt_w[k]), 32'(ed));
      chk({p, " m_en"}, 32'(m_en_w[k]), 32'(ei || ed));
      if (ed) begin
         chk({p, " m_addr d"}, m_addr_w[k], d_addr);
         chk({p, " m_we d"}, 32'(m_we_w[k]), 32'(d_we));
         chk({p, " m_wdata d"}, m_wdata_w[k], d_wdata);
      end else if (ei) begin
         chk({p, " m_addr i"}, m_addr_w[k], i_addr);
         chk({p, " m_we i"}, 32'(m_we_w[k]), 32'd0);
      end else begin
         chk({p, " m_we idle"}, 32'(m_we_w[k]), 32'd0);
         if (have_addr[k]) chk({p, " m_addr hold"}, m_addr_w[k], last_addr[k]);
         if (have_wdata[k]) chk({p, " m_wdata hold"}, m_wdata_w[k], last_wdata[k]);
      end

      s    = cyc % 8;
      iv   = slot_v[k][s] && !slot_d[k][s];
      dv   = slot_v[k][s] && slot_d[k][s];
      rdat = slot_data[k][s];
      chk({p, " i_rvalid"}, 32'(i_rvalid_w[k]), 32'(iv));
      chk({p, " d_rvalid"}, 32'(d_rvalid_w[k]), 32'(dv));
      chk({p, " i_rdata"}, i_rdata_w[k], iv ? rdat : 32'd0);
      chk({p, " d_rdata"}, d_rdata_w[k], dv ? rdat : 32'd0);
      slot_v[k][s] = 1'b0;

      s2 = (cyc + lat_of(k)) % 8;
      if (ed) begin
         last_addr[k]  = d_addr;
         have_addr[k]  = 1'b1;
         last_wdata[k] = d_wdata;
         have_wdata[k] = 1'b1;
         if (d_we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
               if (d_we[b]) ref_mem[k][d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
         end else begin
            slot_v[k][s2]    = 1'b1;
            slot_d[k][s2]    = 1'b1;
            slot_data[k][s2] = ref_mem[k][d_addr[9:2]];
         end
      end
      if (ei) begin
         last_addr[k]     = i_addr;
         have_addr[k]     = 1'b1;
         slot_v[k][s2]    = 1'b1;
         slot_d[k][s2]    = 1'b0;
         slot_data[k][s2] = ref_mem[k][i_addr[9:2]];
      end

      if (!i_req || ei) streak[k] = 0;
      else if (ed && (streak[k] < MAXD)) streak[k] = streak[k] + 1;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) model_check(k);
   end

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic [3:0] we, input logic [31:0] wd);
      @(posedge clk);
      #1;
      i_req   = ir;
      i_addr  = ia;
      d_req   = dr;
      d_addr  = da;
      d_we    = we;
      d_wdata = wd;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   string seq, r0, r1;
   int    stale;
   logic  ig_last, dg_last;

   initial begin
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      // Requests during reset must never be granted.
      #1 i_req = 1'b1; d_req = 1'b1;
      @(negedge clk);
      chk("reset i_gnt", 32'(i_gnt_w[0]), 32'd0);
      chk("reset d_gnt", 32'(d_gnt_w[0]), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;

      // Lone fetch at 0x100
      drive(1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("fetch i_gnt", 32'(i_gnt_w[0]), 32'd1);
      chk("fetch m_en", 32'(m_en_w[0]), 32'd1);
      chk("fetch m_addr", m_addr_w[0], 32'h100);
      idle();
      @(negedge clk);
      chk("fetch i_rvalid", 32'(i_rvalid_w[0]), 32'd1);
      chk("fetch i_rdata", i_rdata_w[0], 32'hA500_0040);
      chk("fetch d_rvalid", 32'(d_rvalid_w[0]), 32'd0);

      // Both requesting for 10 cycles
      seq = "";
      for (int t = 0; t < 10; t++) begin
         drive(1'b1, 32'h104, 1'b1, 32'h200, 4'h0, 32'h0);
         @(negedge clk);
         seq = {seq, gtag(0)};
      end
      chk_str("grant sequence", seq, "DDDDIDDDDI");
      repeat (4) idle();

      // Write then read-back, including a partial byte write
      drive(1'b0, 32'h0, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("write d_gnt", 32'(d_gnt_w[0]), 32'd1);
      chk("write m_we", 32'(m_we_w[0]), 32'hF);
      drive(1'b0, 32'h0, 1'b1, 32'h40, 4'h0, 32'h0);
      @(negedge clk);
      chk("write no rvalid", 32'(d_rvalid_w[0]), 32'd0);
      drive(1'b0, 32'h0, 1'b1, 32'h44, 4'b0010, 32'h0000_7700);
      @(negedge clk);
      chk("rd-after-wr d_rvalid", 32'(d_rvalid_w[0]), 32'd1);
      chk("rd-after-wr d_rdata", d_rdata_w[0], 32'hDEAD_BEEF);
      drive(1'b0, 32'h0, 1'b1, 32'h44, 4'h0, 32'h0);
      @(negedge clk);
      idle();
      @(negedge clk);
      chk("byte write d_rdata", d_rdata_w[0], 32'hA500_7711);
      repeat (3) idle();

      // Alternating I, D, I reads
      r0 = "";
      r1 = "";
      for (int t = 0; t < 6; t++) begin
         case (t)
            0:       drive(1'b1, 32'h108, 1'b0, 32'h0, 4'h0, 32'h0);
            1:       drive(1'b0, 32'h0, 1'b1, 32'h10C, 4'h0, 32'h0);
            2:       drive(1'b1, 32'h110, 1'b0, 32'h0, 4'h0, 32'h0);
            default: idle();
         endcase
         @(negedge clk);
         r0 = {r0, rtag(0)};
         r1 = {r1, rtag(1)};
         if (t == 3) chk("lat3 i_rdata 0x108", i_rdata_w[1], 32'hA500_0042);
         if (t == 4) chk("lat3 d_rdata 0x10C", d_rdata_w[1], 32'hA500_0043);
         if (t == 5) chk("lat3 i_rdata 0x110", i_rdata_w[1], 32'hA500_0044);
      end
      chk_str("lat1 return order", r0, "-IDI--");
      chk_str("lat3 return order", r1, "---IDI");

      // Reset with two reads in flight on the MEM_LAT=3 instance
      drive(1'b1, 32'h120, 1'b0, 32'h0, 4'h0, 32'h0);
      drive(1'b0, 32'h0, 1'b1, 32'h124, 4'h0, 32'h0);
      drive(1'b1, 32'h128, 1'b1, 32'h12C, 4'h0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst i_gnt", 32'(i_gnt_w[1]), 32'd0);
      chk("async rst d_gnt", 32'(d_gnt_w[1]), 32'd0);
      chk("async rst m_en", 32'(m_en_w[1]), 32'd0);
      chk("async rst i_rvalid", 32'(i_rvalid_w[1]), 32'd0);
      chk("async rst d_rvalid", 32'(d_rvalid_w[1]), 32'd0);
      chk("async rst i_rdata", i_rdata_w[1], 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         stale = stale + 32'(i_rvalid_w[0]) + 32'(d_rvalid_w[0])
                       + 32'(i_rvalid_w[1]) + 32'(d_rvalid_w[1]);
      end
      chk("no stale rvalid", 32'(stale), 32'd0);

      // Randomised traffic that honours the hold-until-accepted rule
      ig_last = 1'b0;
      dg_last = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(posedge clk);
         #1;
         if (!(i_req && !ig_last)) begin
            i_req  = 1'($urandom_range(0, 1));
            i_addr = {22'h0, 8'($urandom), 2'b00};
         end
         if (!(d_req && !dg_last)) begin
            d_req   = 1'($urandom_range(0, 1));
            d_addr  = {22'h0, 8'($urandom), 2'b00};
            d_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            d_wdata = $urandom();
         end
         @(negedge clk);
         ig_last = i_gnt_w[0];
         dg_last = d_gnt_w[0];
      end
      repeat (5) idle();

`ifdef MEM_ARB_STATS_EN
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int t = 0; t < 5; t++) drive(1'b1, 32'h104, 1'b1, 32'h200, 4'h0, 32'h0);
      idle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("inst%0d stat_conflict", k), sc_w[k], 32'd5);
         chk($sformatf("inst%0d stat_i_wait", k), si_w[k], 32'd4);
         chk($sformatf("inst%0d stat_d_wait", k), sd_w[k], 32'd1);
      end
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency, pipelined memory between the core's instruction-fetch port and data port (unified-memory build).
- Sits between core and the memory model in the top level.
- Issues at most one memory access per cycle with data-side priority and a bounded anti-starvation rule for fetch.
- Routes read data back to the issuing port using an in-flight owner pipeline.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles (legal 1..4)
MAX_DSTREAK, 4, max consecutive data grants while i_req is waiting (legal 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request (read only)
i_addr  in  AW  fetch address
i_gnt  out  1  fetch accepted this cycle; ~i_gnt & i_req drives core fetch stall
i_rvalid  out  1  fetch read data valid
i_rdata  out  DW  fetch read data
d_req  in  1  data request
d_addr  in  AW  data address
d_we  in  4  byte write enables; 0 = read
d_wdata  in  DW  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid (reads only)
d_rdata  out  DW  data read data
m_en  out  1  memory access strobe
m_addr  out  AW  memory address
m_we  out  4  memory byte write enables
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read strobe

Behaviour:
- Grant is combinational from the req inputs and registered state. Accept = req & gnt in the same cycle. Accept drives m_en/m_addr/m_we/m_wdata in that cycle.
- Requester holds req/addr/we/wdata stable until accepted. It may change them the cycle after.
- Priority: d_req wins over i_req unless dstreak == MAX_DSTREAK and i_req = 1; then i_gnt = 1 and d_gnt = 0.
- dstreak (4-bit) increments on a data grant while i_req = 1. It clears on any fetch grant or any cycle with i_req = 0. It saturates at MAX_DSTREAK.
- Only one requester → that requester is granted. Neither → m_en = 0, m_we = 0, m_addr/m_wdata hold last value.
- Writes (d_we != 0) complete at grant and produce no rvalid.
- Owner pipeline: MEM_LAT-deep shift register of {valid, owner}. On an accepted read, stage 0 ← {1, owner}; otherwise stage 0 ← {0, x}.
- At the last stage, if valid: i_rvalid or d_rvalid = 1 for exactly one cycle, with matching rdata = m_rdata. The other rvalid = 0.
- Back-to-back reads, one per cycle, return in issue order with no bubbles. A read issued the cycle after a write to the same address returns the written data (memory is in-order).
- rdata outputs are a direct mux of m_rdata. They are only meaningful while the matching rvalid = 1; otherwise they are 0.
- Reset (async assert of rst_n = 0):
  - all owner stages invalid, dstreak = 0;
  - i_gnt = d_gnt = 0, i_rvalid = d_rvalid = 0, m_en = 0, m_we = 0, rdata = 0;
  - in-flight reads are discarded and never return.
  - Grants stay 0 while rst_n = 0. Deassertion is synchronised externally; the first grant is possible in the first cycle after release.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: adds outputs stat_conflict, stat_i_wait, stat_d_wait (each 32 bits).
  - stat_conflict increments on cycles with i_req & d_req.
  - stat_i_wait increments on cycles with i_req & ~i_gnt.
  - stat_d_wait increments on cycles with d_req & ~d_gnt.
  - All three saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef owner_e {OWN_I, OWN_D};
  - typedef inflight_t {valid, owner};
  - constants MEM_LAT_MAX = 4 and DSTREAK_W = 4.
- One sub-module, arb_inflight_pipe: the parameterised owner shift register with its reset.
- Grant logic, dstreak and stats stay in the top of the block.

Test Plan:
- MEM_LAT=1; i_req alone at 0x100 → i_gnt=1, m_en=1, m_addr=0x100; next cycle i_rvalid=1 with i_rdata = m_rdata; d_rvalid=0.
- Both req held for 10 cycles, MAX_DSTREAK=4 → grant sequence D,D,D,D,I,D,D,D,D,I; dstreak clears after each I.
- d write 0xDEADBEEF, d_we=0xF, @0x40; next cycle d read @0x40 → no rvalid for the write; d_rvalid one cycle later with 0xDEADBEEF.
- MEM_LAT=3; issue alternating I,D,I reads on consecutive cycles → rvalids return in cycles 3,4,5 as I,D,I with correct data routing.
- Assert rst_n=0 with 2 reads in flight (MEM_LAT=3) → all outputs 0 immediately; after release no stale rvalid appears.
- With MEM_ARB_STATS_EN: 5 cycles of both requesting → stat_conflict=5, stat_i_wait=4, stat_d_wait=1.
